mem_port_arbiter: RTL and testbench

- Shares one single-ported instruction/data memory between the fetch stage (IF) and the memory stage (DM) of the 5-stage pipeline.
- Issues one transaction at a time to a variable-latency memory using a req/ack handshake.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Generates stall_f/stall_m for the hazard unit. Data accesses have priority; a burst limit prevents fetch starvation, and a timeout prevents a hung bus.

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch stage
// (IF) and the memory stage (DM). One transaction is in flight at a time. The
// memory handshake is req/ack with variable latency, and there is a
// wait-state timeout.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | no transaction in flight; arbitrate between IF and DM
//   S_IF_WAIT | fetch issued on mem_*, waiting for mem_ack or timeout
//   S_DM_WAIT | load/store issued on mem_*, waiting for mem_ack or timeout
//
// Data accesses win ties. A requester is never re-granted in its own ready
// cycle, because its pipeline stage has not advanced yet at that point.
// burst_q counts DM grants made while fetch was kept waiting. Once it reaches
// MAX_DM_BURST, fetch wins the next tie.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DM_BURST = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wmask,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            bus_err,
  output logic            stall_f,
  output logic            stall_m
);

  localparam int MW = DW / 8;
  localparam int BW = (MAX_DM_BURST < 1) ? 1 : $clog2(MAX_DM_BURST + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DM_BURST);
  // The abort fires when the increment would reach TIMEOUT. The counter
  // therefore never holds TIMEOUT itself.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_WAIT = 2'd1,
    S_DM_WAIT = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [BW-1:0]   burst_q,     burst_d;
  logic [TW-1:0]   tmo_q,       tmo_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MW-1:0]   mem_wmask_q, mem_wmask_d;
  logic            if_ready_q,  if_ready_d;
  logic            dm_ready_q,  dm_ready_d;
  logic            bus_err_q,   bus_err_d;
  logic [DW-1:0]   if_rdata_q,  if_rdata_d;
  logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;

  logic if_elig;
  logic dm_elig;
  logic dm_win;
  logic in_wait;
  logic tmo_hit;

  // Eligibility masks the requester's own ready cycle.
  always_comb begin
    if_elig = if_req & ~if_ready_q;
    dm_elig = dm_req & ~dm_ready_q;
    dm_win  = dm_elig & (~if_elig | (burst_q < BURST_MAX));
    in_wait = (state_q == S_IF_WAIT) | (state_q == S_DM_WAIT);
    tmo_hit = in_wait & ~mem_ack & (tmo_q == TMO_LAST);
  end

  // Next-state, capture, completion and abort logic.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dm_win) begin
          state_d     = S_DM_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wmask_d = dm_wmask;
          tmo_d       = '0;
          if (if_elig) begin
            burst_d = (burst_q == BURST_MAX) ? BURST_MAX : burst_q + 1'b1;
          end else begin
            burst_d = '0;
          end
        end else if (if_elig) begin
          state_d     = S_IF_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wmask_d = '0;
          tmo_d       = '0;
          burst_d     = '0;
        end
      end

      S_IF_WAIT: begin
        if (mem_ack) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata;
        end else if (tmo_hit) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          bus_err_d  = 1'b1;
          if_rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DM_WAIT: begin
        if (mem_ack) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (tmo_hit) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          bus_err_d  = 1'b1;
          dm_rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // A reset in the middle of a transaction abandons it without a ready pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Output mapping; the stalls are combinational so the hazard unit sees
  // them drop exactly in the ready cycle.
  always_comb begin
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_wmask = mem_wmask_q;
    if_ready  = if_ready_q;
    dm_ready  = dm_ready_q;
    bus_err   = bus_err_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    stall_f   = if_req & ~if_ready_q;
    stall_m   = dm_req & ~dm_ready_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level reference model
// tracks who owns the bus, how many wait cycles it has spent, the DM burst
// count and the outputs each requester should see.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MW   = DW / 8;
  localparam int MAXB = 4;
  localparam int TMO  = 8;
  localparam int NCYC = 6000;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [MW-1:0] dm_wmask;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          bus_err;
  logic          stall_f;
  logic          stall_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_DM_BURST(MAXB), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .stall_f(stall_f), .stall_m(stall_m)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. owner: 0 = bus free, 1 = fetch, 2 = data.
  int            owner;
  int            waits;
  int            burst;
  int            ack_delay;
  logic          e_if_ready, e_dm_ready, e_bus_err, e_mem_req, e_mem_we;
  logic [DW-1:0] e_if_rdata, e_dm_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;
  logic [MW-1:0] e_mem_wmask;
  int            n_aborts, n_grants;

  task automatic model_clear();
    owner = 0; waits = 0; burst = 0; ack_delay = 0;
    e_if_ready = 0; e_dm_ready = 0; e_bus_err = 0; e_mem_req = 0; e_mem_we = 0;
    e_if_rdata = '0; e_dm_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0; e_mem_wmask = '0;
  endtask

  // Memory behaviour per transaction: short latency, ack in the last legal
  // wait cycle, ack one cycle earlier, or no ack at all.
  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return r % 4;
    if (r < 7) return TMO - 1;
    if (r == 7) return TMO - 2;
    return NEVER;
  endfunction

  task automatic model_finish(input bit err);
    if (owner == 1) begin
      e_if_ready = 1;
      e_if_rdata = err ? '0 : mem_rdata;
    end else begin
      e_dm_ready = 1;
      if (err) e_dm_rdata = '0;
      else if (!e_mem_we) e_dm_rdata = mem_rdata;
    end
    e_bus_err = err;
    if (err) n_aborts++;
    owner = 0;
  endtask

  // One clock edge of the reference, using the inputs held across that edge.
  task automatic model_step();
    bit fe, de;
    if (reset) begin
      model_clear();
      return;
    end
    fe = if_req && !e_if_ready;
    de = dm_req && !e_dm_ready;
    e_if_ready = 0;
    e_dm_ready = 0;
    e_bus_err  = 0;
    if (owner == 0) begin
      if (de && (!fe || burst < MAXB)) begin
        owner       = 2;
        e_mem_we    = dm_we;
        e_mem_addr  = dm_addr;
        e_mem_wdata = dm_wdata;
        e_mem_wmask = dm_wmask;
        burst       = fe ? ((burst < MAXB) ? burst + 1 : MAXB) : 0;
      end else if (fe) begin
        owner       = 1;
        e_mem_we    = 0;
        e_mem_addr  = if_addr;
        e_mem_wmask = '0;
        burst       = 0;
      end
      if (owner != 0) begin
        waits     = 0;
        ack_delay = pick_delay();
        n_grants++;
      end
    end else begin
      waits++;
      if (mem_ack) model_finish(1'b0);
      else if (waits == TMO) model_finish(1'b1);
    end
    e_mem_req = (owner != 0);
  endtask

  task automatic check_all();
    check_val("if_ready",  32'(if_ready),  32'(e_if_ready));
    check_val("dm_ready",  32'(dm_ready),  32'(e_dm_ready));
    check_val("bus_err",   32'(bus_err),   32'(e_bus_err));
    check_val("mem_req",   32'(mem_req),   32'(e_mem_req));
    check_val("if_rdata",  if_rdata,       e_if_rdata);
    check_val("dm_rdata",  dm_rdata,       e_dm_rdata);
    check_val("stall_f",   32'(stall_f),   32'(if_req & ~e_if_ready));
    check_val("stall_m",   32'(stall_m),   32'(dm_req & ~e_dm_ready));
    check_val("rdy_excl",  32'(if_ready & dm_ready), 32'(0));
    check_val("err_alone", 32'(bus_err & ~(if_ready | dm_ready)), 32'(0));
    if (e_mem_req) begin
      check_val("mem_we",    32'(mem_we),    32'(e_mem_we));
      check_val("mem_addr",  mem_addr,       e_mem_addr);
      check_val("mem_wmask", 32'(mem_wmask), 32'(e_mem_wmask));
      if (owner == 2) check_val("mem_wdata", mem_wdata, e_mem_wdata);
    end
  endtask

  // Drive the inputs for the coming cycle; called just after the falling edge.
  task automatic drive_inputs();
    if (reset) begin
      reset = 1'b0;
    end else if ($urandom_range(0, 299) == 0) begin
      reset  = 1'b1;
      if_req = 1'b0;
      dm_req = 1'b0;
      model_clear();
    end
    if (!reset) begin
      if (!e_if_ready && $urandom_range(0, 4) == 0) if_req = !if_req;
      if (!e_dm_ready && $urandom_range(0, 4) == 0) dm_req = !dm_req;
    end
    if ($urandom_range(0, 1) == 0) if_addr = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      dm_we    = 1'($urandom);
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      dm_wmask = MW'($urandom);
    end
    mem_rdata = $urandom;
    if (e_mem_req) mem_ack = (waits == ack_delay);
    else           mem_ack = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    n_aborts = 0;
    n_grants = 0;
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_wmask = '0;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    model_clear();
    #1;
    check_all();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      drive_inputs();
      #1;
      check_all();
    end
    check_val("grants_seen", 32'(n_grants > 100), 32'(1));
    check_val("aborts_seen", 32'(n_aborts > 5),   32'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
